// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  typedef enum logic [3:0] {
    CL_R,
    CL_IALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_AUIPC,
    CL_ILL
  } class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_JUMP = 5'b10000;
  localparam logic [1:0] BR_COND = 2'b01;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/instr_class_decode.sv
// Maps opcode/funct3 onto an instruction class and flags unsupported encodings.
module instr_class_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [3:0] cls,
  output logic       legal
);

  always_comb begin
    cls   = CL_ILL;
    legal = 1'b1;
    case (opcode)
      OP_R:      cls = CL_R;
      OP_IALU:   cls = CL_IALU;
      OP_LOAD:   cls = CL_LOAD;
      OP_STORE:  cls = CL_STORE;
      OP_BRANCH: begin
        cls   = CL_BRANCH;
        // funct3 010/011 have no branch meaning in RV32I
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OP_JAL:    cls = CL_JAL;
      OP_JALR:   cls = CL_JALR;
      OP_LUI:    cls = CL_LUI;
      OP_AUIPC:  cls = CL_AUIPC;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a sticky TRAP.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic [4:0]  BrOp,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RUWr,
  output logic        DMRd,
  output logic        DMWr,
  output logic        ALUASrc,
  output logic        ALUBSrc,
  output logic [3:0]  ALUOp,
  output logic [2:0]  ImmSrc,
  output logic [1:0]  RUDataWrSrc,
  output logic        illegal
);

  state_t     state, next_state;
  class_t     cls;
  logic [3:0] cls_code;
  logic       legal;
  logic [2:0] funct3;
  logic       unused_instr;

  assign funct3       = instr[14:12];
  assign cls          = class_t'(cls_code);
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  instr_class_decode u_decode (
    .opcode (instr[6:0]),
    .funct3 (funct3),
    .cls    (cls_code),
    .legal  (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    BrOp        = BR_NONE;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    RUWr        = 1'b0;
    DMRd        = 1'b0;
    DMWr        = 1'b0;
    ALUASrc     = 1'b0;
    ALUBSrc     = 1'b0;
    ALUOp       = 4'b0000;
    ImmSrc      = IMM_I;
    RUDataWrSrc = WB_ALU;
    illegal     = 1'b0;

    // Datapath selects follow the latched instruction once it is decoded
    if (state inside {DECODE, EXEC, MEM, WB}) begin
      ALUBSrc = (cls != CL_R);
      ALUASrc = (cls inside {CL_BRANCH, CL_JAL, CL_AUIPC});
      case (cls)
        CL_R:    ALUOp = {instr[30], funct3};
        CL_IALU: ALUOp = {instr[30] & (funct3 == 3'b101), funct3};
        default: ALUOp = 4'b0000;
      endcase
      case (cls)
        CL_STORE:         ImmSrc = IMM_S;
        CL_BRANCH:        ImmSrc = IMM_B;
        CL_LUI, CL_AUIPC: ImmSrc = IMM_U;
        CL_JAL:           ImmSrc = IMM_J;
        default:          ImmSrc = IMM_I;
      endcase
      case (cls)
        CL_LOAD:         RUDataWrSrc = WB_MEM;
        CL_JAL, CL_JALR: RUDataWrSrc = WB_PC4;
        default:         RUDataWrSrc = WB_ALU;
      endcase
    end

    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        next_state = DECODE;
      end
      DECODE: next_state = legal ? EXEC : TRAP;
      EXEC: begin
        case (cls)
          CL_BRANCH: begin
            BrOp       = {BR_COND, funct3};
            PCWrite    = 1'b1;
            next_state = FETCH;
          end
          CL_JAL, CL_JALR: begin
            BrOp       = BR_JUMP;
            PCWrite    = 1'b1;
            next_state = WB;
          end
          CL_LOAD, CL_STORE: next_state = MEM;
          default:           next_state = WB;
        endcase
      end
      MEM: begin
        DMRd = (cls == CL_LOAD);
        DMWr = (cls != CL_LOAD);
        if (mem_ready) begin
          if (cls == CL_LOAD) begin
            next_state = WB;
          end else begin
            PCWrite    = 1'b1;
            next_state = FETCH;
          end
        end
      end
      WB: begin
        RUWr       = 1'b1;
        PCWrite    = !(cls inside {CL_JAL, CL_JALR});
        next_state = FETCH;
      end
      TRAP: begin
        illegal    = 1'b1;
        next_state = TRAP;
      end
      default: next_state = FETCH;
    endcase

    // Reset silences every output immediately, without waiting for a clock
    if (!rst_n) begin
      BrOp        = BR_NONE;
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      RUWr        = 1'b0;
      DMRd        = 1'b0;
      DMWr        = 1'b0;
      ALUASrc     = 1'b0;
      ALUBSrc     = 1'b0;
      ALUOp       = 4'b0000;
      ImmSrc      = IMM_I;
      RUDataWrSrc = WB_ALU;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed cycle-by-cycle bench for control_fsm.
module tb_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic [4:0]  BrOp;
  logic        PCWrite, IRWrite, RUWr, DMRd, DMWr;
  logic        ALUASrc, ALUBSrc;
  logic [3:0]  ALUOp;
  logic [2:0]  ImmSrc;
  logic [1:0]  RUDataWrSrc;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  // {BrOp, PCWrite, IRWrite, RUWr, DMRd, DMWr, illegal}
  logic [10:0] strb;
  assign strb = {BrOp, PCWrite, IRWrite, RUWr, DMRd, DMWr, illegal};

  localparam logic [10:0] X_IDLE  = {5'b00000, 6'b000000};
  localparam logic [10:0] X_FETCH = {5'b00000, 6'b010000};
  localparam logic [10:0] X_TRAP  = {5'b00000, 6'b000001};
  localparam logic [10:0] X_RD    = {5'b00000, 6'b000100};
  localparam logic [10:0] X_WR    = {5'b00000, 6'b000010};
  localparam logic [10:0] X_WRDON = {5'b00000, 6'b100010};
  localparam logic [10:0] X_WBPC  = {5'b00000, 6'b101000};
  localparam logic [10:0] X_WBJ   = {5'b00000, 6'b001000};
  localparam logic [10:0] X_BEQ   = {5'b01000, 6'b100000};
  localparam logic [10:0] X_BGEU  = {5'b01111, 6'b100000};
  localparam logic [10:0] X_JUMP  = {5'b10000, 6'b100000};

  control_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .mem_ready   (mem_ready),
    .BrOp        (BrOp),
    .PCWrite     (PCWrite),
    .IRWrite     (IRWrite),
    .RUWr        (RUWr),
    .DMRd        (DMRd),
    .DMWr        (DMWr),
    .ALUASrc     (ALUASrc),
    .ALUBSrc     (ALUBSrc),
    .ALUOp       (ALUOp),
    .ImmSrc      (ImmSrc),
    .RUDataWrSrc (RUDataWrSrc),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the DUT in cycle 1 (FETCH) just after reset release
  task automatic start(input logic [31:0] ins);
    rst_n     = 1'b0;
    instr     = ins;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; instr = 32'h00000063; mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (strb !== X_IDLE) begin
      bad++; $display("FAIL reset_strobes: got %b want %b", strb, X_IDLE);
    end
    total++;
    if ({ALUASrc, ALUBSrc, ALUOp, ImmSrc, RUDataWrSrc} !== 11'b0) begin
      bad++; $display("FAIL reset_selects: got %b want %b",
                      {ALUASrc, ALUBSrc, ALUOp, ImmSrc, RUDataWrSrc}, 11'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (strb !== X_FETCH) begin
      bad++; $display("FAIL first_fetch: got %b want %b", strb, X_FETCH);
    end
  endtask

  task automatic test_beq;
    logic [10:0] exp;
    start(32'h00000063);
    for (int c = 1; c <= 4; c++) begin
      case (c)
        1, 4:    exp = X_FETCH;
        3:       exp = X_BEQ;
        default: exp = X_IDLE;
      endcase
      @(negedge clk);
      total++;
      if (strb !== exp) begin
        bad++; $display("FAIL beq_c%0d: got %b want %b", c, strb, exp);
      end
      if (c == 3) begin
        total++;
        if ({ALUASrc, ALUBSrc, ImmSrc} !== 5'b11010) begin
          bad++; $display("FAIL beq_sel: got %b want %b", {ALUASrc, ALUBSrc, ImmSrc}, 5'b11010);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bgeu;
    logic [10:0] exp;
    start(32'h00007063);
    for (int c = 1; c <= 4; c++) begin
      case (c)
        1, 4:    exp = X_FETCH;
        3:       exp = X_BGEU;
        default: exp = X_IDLE;
      endcase
      @(negedge clk);
      total++;
      if (strb !== exp) begin
        bad++; $display("FAIL bgeu_c%0d: got %b want %b", c, strb, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_trap;
    logic [10:0] exp;
    start(32'h00002063);
    for (int c = 1; c <= 14; c++) begin
      case (c)
        1:       exp = X_FETCH;
        2:       exp = X_IDLE;
        default: exp = X_TRAP;
      endcase
      @(negedge clk);
      total++;
      if (strb !== exp) begin
        bad++; $display("FAIL br010_trap_c%0d: got %b want %b", c, strb, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw;
    logic [10:0] exp;
    start(32'h0000a083);
    for (int c = 1; c <= 9; c++) begin
      mem_ready = (c == 7);
      case (c)
        1, 9:       exp = X_FETCH;
        4, 5, 6, 7: exp = X_RD;
        8:          exp = X_WBPC;
        default:    exp = X_IDLE;
      endcase
      @(negedge clk);
      total++;
      if (strb !== exp) begin
        bad++; $display("FAIL lw_c%0d: got %b want %b", c, strb, exp);
      end
      if (c == 3) begin
        total++;
        if ({ALUOp, ImmSrc, ALUBSrc} !== 8'b0000_000_1) begin
          bad++; $display("FAIL lw_exec_sel: got %b want %b", {ALUOp, ImmSrc, ALUBSrc}, 8'b0000_000_1);
        end
      end
      if (c == 8) begin
        total++;
        if (RUDataWrSrc !== 2'b01) begin
          bad++; $display("FAIL lw_wbsrc: got %b want %b", RUDataWrSrc, 2'b01);
        end
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_sw;
    logic [10:0] exp;
    start(32'h0000a023);
    for (int c = 1; c <= 6; c++) begin
      mem_ready = (c == 5);
      case (c)
        1, 6:    exp = X_FETCH;
        4:       exp = X_WR;
        5:       exp = X_WRDON;
        default: exp = X_IDLE;
      endcase
      @(negedge clk);
      total++;
      if (strb !== exp) begin
        bad++; $display("FAIL sw_c%0d: got %b want %b", c, strb, exp);
      end
      if (c == 3) begin
        total++;
        if (ImmSrc !== 3'b001) begin
          bad++; $display("FAIL sw_imm: got %b want %b", ImmSrc, 3'b001);
        end
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_jal;
    logic [10:0] exp;
    start(32'h000000ef);
    for (int c = 1; c <= 5; c++) begin
      case (c)
        1, 5:    exp = X_FETCH;
        3:       exp = X_JUMP;
        4:       exp = X_WBJ;
        default: exp = X_IDLE;
      endcase
      @(negedge clk);
      total++;
      if (strb !== exp) begin
        bad++; $display("FAIL jal_c%0d: got %b want %b", c, strb, exp);
      end
      if (c == 3) begin
        total++;
        if ({ALUASrc, ImmSrc, ALUOp} !== 8'b1_100_0000) begin
          bad++; $display("FAIL jal_sel: got %b want %b", {ALUASrc, ImmSrc, ALUOp}, 8'b1_100_0000);
        end
      end
      if (c == 4) begin
        total++;
        if (RUDataWrSrc !== 2'b10) begin
          bad++; $display("FAIL jal_wbsrc: got %b want %b", RUDataWrSrc, 2'b10);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // sub x3,x1,x2 then sub x0,x1,x2: both must pulse RUWr
  task automatic test_r_type;
    logic [10:0] exp;
    logic [31:0] prog [2];
    prog[0] = 32'h402081b3;
    prog[1] = 32'h40208033;
    for (int k = 0; k < 2; k++) begin
      start(prog[k]);
      for (int c = 1; c <= 5; c++) begin
        case (c)
          1, 5:    exp = X_FETCH;
          4:       exp = X_WBPC;
          default: exp = X_IDLE;
        endcase
        @(negedge clk);
        total++;
        if (strb !== exp) begin
          bad++; $display("FAIL rtype%0d_c%0d: got %b want %b", k, c, strb, exp);
        end
        if (c == 3) begin
          total++;
          if ({ALUOp, ALUASrc, ALUBSrc} !== 6'b1000_00) begin
            bad++; $display("FAIL rtype%0d_sel: got %b want %b", k, {ALUOp, ALUASrc, ALUBSrc}, 6'b1000_00);
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // funct3/bit30 positions carry immediate bits for AUIPC; ALUOp must stay add
  task automatic test_auipc;
    start(32'h40007097);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) begin
        total++;
        if ({ALUOp, ALUASrc, ALUBSrc, ImmSrc} !== 9'b0000_1_1_011) begin
          bad++; $display("FAIL auipc_sel: got %b want %b", {ALUOp, ALUASrc, ALUBSrc, ImmSrc}, 9'b0000_1_1_011);
        end
      end
      if (c == 4) begin
        total++;
        if (strb !== X_WBPC) begin
          bad++; $display("FAIL auipc_wb: got %b want %b", strb, X_WBPC);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_opcode;
    start(32'h0000007f);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        total++;
        if (strb !== X_TRAP) begin
          bad++; $display("FAIL badop_c%0d: got %b want %b", c, strb, X_TRAP);
        end
      end
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (illegal !== 1'b0) begin
      bad++; $display("FAIL badop_reset_clears: got %b want %b", illegal, 1'b0);
    end
  endtask

  task automatic test_reset_mid_mem;
    start(32'h0000a023);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (DMWr !== 1'b1) begin
      bad++; $display("FAIL midmem_dmwr_before: got %b want %b", DMWr, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (strb !== X_IDLE) begin
      bad++; $display("FAIL midmem_async_drop: got %b want %b", strb, X_IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (strb !== X_FETCH) begin
      bad++; $display("FAIL midmem_refetch: got %b want %b", strb, X_FETCH);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    test_reset();
    test_beq();
    test_bgeu();
    test_branch_trap();
    test_lw();
    test_sw();
    test_jal();
    test_r_type();
    test_auipc();
    test_illegal_opcode();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
